axi_read_slv: RTL and testbench
===============================

AXI_READ_SLV -- requirements
Module: axi_read_slv

Interface
REQ-001 Parameter ID_W, default 7, width of arid/rid.
REQ-002 Parameter ADDR_W, default 32, width of araddr.
REQ-003 Parameter DATA_W, default 256, width of rdata; SHALL be a multiple of 32.
REQ-004 Parameter CMD_DEPTH, default 4, depth of AR command FIFO, power of 2.
REQ-005 Parameter RD_LAT, default 2, cycles between command pop and first rvalid.
REQ-006 i_clk  input  1  single clock; all logic on its rising edge.
REQ-007 i_reset  input  1  reset, synchronous, active-high.
REQ-008 arid  input  ID_W  read address ID.
REQ-009 araddr  input  ADDR_W  burst start byte address.
REQ-010 arlen  input  8  beats minus one.
REQ-011 arsize  input  3  log2 bytes per beat.
REQ-012 arburst  input  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-013 arvalid  input  1  AR valid.
REQ-014 arready  output  1  AR ready.
REQ-015 rid  output  ID_W  ID of the current burst.
REQ-016 rdata  output  DATA_W  beat data.
REQ-017 rresp  output  2  0 OKAY, 2 SLVERR.
REQ-018 rlast  output  1  last beat of burst.
REQ-019 rvalid  output  1  R valid.
REQ-020 rready  input  1  R ready.

Function
REQ-021 AR handshake (arvalid&arready at a rising edge) SHALL push {arid,araddr,arlen,arsize,arburst} into the FIFO.
REQ-022 arready SHALL equal !fifo_full & !i_reset; push while full is impossible; no bypass path.
REQ-023 Read engine FSM states: IDLE, WAIT, DATA.
REQ-024 IDLE: when FIFO non-empty, pop one command, load the beat counter to 0 and the latency counter to RD_LAT, then go to WAIT (or to DATA directly if RD_LAT=0).
REQ-025 WAIT: decrement the latency counter each cycle; on reaching 0, go to DATA.
REQ-026 DATA: rvalid=1; on rvalid&rready, advance beat; on the handshake with rlast=1, return to IDLE (one idle cycle between bursts).
REQ-027 Push and pop in the same cycle SHALL both take effect; the FIFO count is unchanged.
REQ-028 rid, rdata, rresp and rlast SHALL be held stable while rvalid=1 and rready=0.
REQ-029 rlast=1 exactly when beat index == arlen of the current command.
REQ-030 Beat address, INCR: (araddr & ~(2^arsize-1)) + n*2^arsize, computed modulo 2^ADDR_W.
REQ-031 Beat address, FIXED: araddr for every beat.
REQ-032 Beat address, WRAP: boundary = (arlen+1)*2^arsize; address = base + ((araddr + n*2^arsize) mod boundary), base = araddr aligned down to boundary.
REQ-033 rdata 32-bit lane k (k = 0..DATA_W/32-1) SHALL equal beat_addr + 4*k, truncated to 32 bits.
REQ-034 Error condition: arburst=3, or 2^arsize > DATA_W/8, or WRAP with arlen not in {1,3,7,15}.
REQ-035 On an error burst: arlen+1 beats still issued, rresp=2 and rdata=0 on every beat, rid/rlast as normal.
REQ-036 Non-error beats SHALL return rresp=0.
REQ-037 Latency: with the AR handshake at edge E0 and rready=1, first rvalid=1 SHALL be visible after edge E0+1+RD_LAT.
REQ-038 Capacity: CMD_DEPTH commands in the FIFO plus one in the engine; arready SHALL reassert on the cycle after a pop from a full FIFO.

Reset
REQ-039 While i_reset=1 at an edge: FIFO emptied, FSM to IDLE, all counters 0.
REQ-040 Reset values: rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, arready=0.
REQ-041 Reset asserted mid-burst SHALL abort the burst with no further beats; the first cycle after release has arready=1 and rvalid=0.

Verification
REQ-042 INCR: arid=0x12, araddr=0x1000, arlen=3, arsize=5, rready=1 -> 4 beats, lane0 = 0x1000/0x1020/0x1040/0x1060, lane7 = lane0+0x1C, rid=0x12, rresp=0, rlast on beat 4 only, first rvalid after E0+3.
REQ-043 Backpressure: same burst, rready toggling 1,0,0,1,... -> rdata/rlast/rid unchanged while stalled, exactly 4 handshakes.
REQ-044 Full: 6 back-to-back ARs with rready=0 -> 5 accepted, arready=0 for the 6th until the first burst's last beat is taken, then 6th accepted.
REQ-045 WRAP: araddr=0x1030, arlen=3, arsize=4 -> lane0 = 0x1030, 0x1000, 0x1010, 0x1020.
REQ-046 Error: arburst=3, arlen=1 -> 2 beats, rresp=2, rdata=0, rlast on beat 2; a following INCR burst returns rresp=0.
REQ-047 Reset during beat 2 of an arlen=7 burst -> rvalid=0 on the next cycle, FIFO empty, a new AR is accepted and served normally.

Source files
------------

// File: rtl/axi_read_slv.sv
// AXI read slave: AR commands queue in a small FIFO; one engine replays each burst after RD_LAT
// cycles with address-pattern data. Error bursts (reserved type, oversize beat, bad wrap length) return SLVERR.
module axi_read_slv #(
    parameter int ID_W      = 7,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int CMD_DEPTH = 4,
    parameter int RD_LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam int LANES = DATA_W / 32;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    cmd_t             fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             fifo_full, fifo_empty, push, pop;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [7:0]       beat_q, beat_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    logic [ADDR_W-1:0] size_bytes, beat_off, wrap_bound, beat_addr;
    logic [31:0]       addr32;
    logic [DATA_W-1:0] beat_data;
    logic              burst_err, in_data, last_beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == (PTR_W + 1)'(CMD_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign arready    = !fifo_full && !i_reset;
    assign push       = arvalid && arready;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    assign last_beat = (beat_q == cmd_q.len);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cmd_d   = fifo_mem_q[rd_ptr_q];
                    beat_d  = '0;
                    lat_d   = LAT_W'(RD_LAT);
                    state_d = (RD_LAT == 0) ? S_DATA : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    lat_d   = '0;
                    state_d = S_DATA;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_DATA: begin
                if (rready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat address from the latched command; wrap boundaries are powers of two for legal wrap lengths
    always_comb begin
        size_bytes = ADDR_W'(1) << cmd_q.size;
        beat_off   = ADDR_W'(beat_q) << cmd_q.size;
        wrap_bound = (ADDR_W'(cmd_q.len) + ADDR_W'(1)) << cmd_q.size;
        case (cmd_q.burst)
            2'd1:    beat_addr = (cmd_q.addr & ~(size_bytes - 1'b1)) + beat_off;
            2'd2:    beat_addr = (cmd_q.addr & ~(wrap_bound - 1'b1))
                               + ((cmd_q.addr + beat_off) & (wrap_bound - 1'b1));
            default: beat_addr = cmd_q.addr;
        endcase
        addr32 = 32'(beat_addr);
        beat_data = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_data[k*32 +: 32] = addr32 + 32'(4 * k);
        end
    end

    assign burst_err = (cmd_q.burst == 2'd3) || (cmd_q.size > MAX_SIZE)
                     || ((cmd_q.burst == 2'd2) && !(cmd_q.len inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // Output logic: everything reads zero outside DATA
    assign in_data = (state_q == S_DATA);

    always_comb begin
        rvalid = in_data;
        rid    = in_data ? cmd_q.id : '0;
        rlast  = in_data && last_beat;
        rresp  = (in_data && burst_err) ? 2'd2 : 2'd0;
        rdata  = (in_data && !burst_err) ? beat_data : '0;
    end

endmodule

// File: tb/tb_axi_read_slv.sv
// Bench for axi_read_slv: burst-level reference model plus directed scenarios with literal expectations.
module tb_axi_read_slv;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic [6:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [6:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    always #5 i_clk = ~i_clk;

    axi_read_slv #(.ID_W(7), .ADDR_W(32), .DATA_W(256), .CMD_DEPTH(4), .RD_LAT(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic [6:0]   id;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    beat_t        exp_q[$];
    logic [31:0]  hs_lane0[$];
    logic [31:0]  hs_lane7[$];
    logic [6:0]   hs_id[$];
    logic [1:0]   hs_resp[$];
    logic         hs_last[$];

    logic         prev_stall = 1'b0;
    logic [255:0] prev_data;
    logic [6:0]   prev_id;
    logic [1:0]   prev_resp;
    logic         prev_last;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: expand one AR command into its beats straight from the burst arithmetic
    task automatic model_push(input logic [6:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        longint sz = longint'(1) << size;
        longint a0 = longint'(addr);
        longint bound = (longint'(len) + 1) * sz;
        bit err = (burst == 2'd3) || (sz > 32)
                  || ((burst == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int n = 0; n <= int'(len); n++) begin
            longint a;
            beat_t b;
            if (burst == 2'd1)      a = (a0 / sz) * sz + n * sz;
            else if (burst == 2'd2) a = (a0 / bound) * bound + ((a0 + n * sz) % bound);
            else                    a = a0;
            b.id   = id;
            b.resp = err ? 2'd2 : 2'd0;
            b.last = (n == int'(len));
            b.data = '0;
            for (int k = 0; k < 8; k++) begin
                b.data[k*32 +: 32] = err ? 32'd0 : 32'(a + 4 * k);
            end
            exp_q.push_back(b);
        end
    endtask

    // Compare process: every cycle rvalid is high, and on every AR handshake
    always @(negedge i_clk) begin
        if (i_reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_rvalid", rvalid, 1'b1);
                chk("stall_rdata", rdata, prev_data);
                chk("stall_rid", rid, prev_id);
                chk("stall_rresp", rresp, prev_resp);
                chk("stall_rlast", rlast, prev_last);
            end
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: rvalid=1 rid=%h but no beat expected", rid);
                end else begin
                    chk("beat_rid", rid, exp_q[0].id);
                    chk("beat_rdata", rdata, exp_q[0].data);
                    chk("beat_rresp", rresp, exp_q[0].resp);
                    chk("beat_rlast", rlast, exp_q[0].last);
                    if (rready) begin
                        hs_lane0.push_back(rdata[31:0]);
                        hs_lane7.push_back(rdata[255:224]);
                        hs_id.push_back(rid);
                        hs_resp.push_back(rresp);
                        hs_last.push_back(rlast);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (arvalid && arready) model_push(arid, araddr, arlen, arsize, arburst);
            prev_stall = rvalid && !rready;
            prev_data  = rdata;
            prev_id    = rid;
            prev_resp  = rresp;
            prev_last  = rlast;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic clear_log();
        hs_lane0.delete(); hs_lane7.delete(); hs_id.delete(); hs_resp.delete(); hs_last.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the handshake edge with e0 = that edge's index
    task automatic send_ar(input logic [6:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int e0);
        bit ok = 1'b0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_accept: arready stayed 0 for id %h, required 1", id);
        end
        @(posedge i_clk);
        #1;
        e0 = cyc;
        arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (exp_q.size() == 0 && !rvalid) begin done = 1'b1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: %0d beats still pending, required 0", exp_q.size());
        end
    endtask

    int e0, first, ev[5];
    logic [31:0] exp_l0[4];

    initial begin
        i_reset = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (3) tick();
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rresp", rresp, 2'd0);
        chk("rst_rid", rid, 7'd0);
        chk("rst_rdata", rdata, 256'd0);
        @(posedge i_clk); #1; i_reset = 1'b0;
        tick();
        chk("post_rst_arready", arready, 1'b1);
        chk("post_rst_rvalid", rvalid, 1'b0);

        // INCR burst with latency measurement
        clear_log(); rready = 1'b1;
        @(posedge i_clk); #1;
        send_ar(7'h12, 32'h1000, 8'd3, 3'd5, 2'd1, e0);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rvalid) begin first = cyc; break; end
        end
        chk("incr_latency", 256'(first - e0), 256'd3);
        wait_idle(50);
        exp_l0 = '{32'h1000, 32'h1020, 32'h1040, 32'h1060};
        chk("incr_beats", 256'(hs_lane0.size()), 256'd4);
        for (int i = 0; i < 4 && i < hs_lane0.size(); i++) begin
            chk("incr_lane0", hs_lane0[i], exp_l0[i]);
            chk("incr_lane7", hs_lane7[i], exp_l0[i] + 32'h1C);
            chk("incr_rid", hs_id[i], 7'h12);
            chk("incr_rresp", hs_resp[i], 2'd0);
            chk("incr_rlast", hs_last[i], (i == 3));
        end

        // Same burst under rready pattern 1,0,0,1
        clear_log();
        @(posedge i_clk); #1;
        send_ar(7'h12, 32'h1000, 8'd3, 3'd5, 2'd1, e0);
        for (int i = 0; i < 100; i++) begin
            if (hs_lane0.size() == 4 && exp_q.size() == 0) break;
            @(posedge i_clk); #1;
            rready = ((i % 4) == 0) || ((i % 4) == 3);
        end
        rready = 1'b1;
        wait_idle(50);
        chk("bp_beats", 256'(hs_lane0.size()), 256'd4);
        for (int i = 0; i < 4 && i < hs_lane0.size(); i++) chk("bp_lane0", hs_lane0[i], exp_l0[i]);

        // FIFO full: 5 accepted back to back, 6th waits for the first burst to finish
        clear_log(); rready = 1'b0;
        @(posedge i_clk); #1;
        for (int i = 0; i < 5; i++) send_ar(7'(i + 1), 32'(32'h100 * (i + 1)), 8'd1, 3'd5, 2'd1, ev[i]);
        chk("full_b2b_accept", 256'(ev[4] - ev[0]), 256'd4);
        arid = 7'd6; araddr = 32'h600; arlen = 8'd1; arsize = 3'd5; arburst = 2'd1; arvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("full_arready", arready, 1'b0);
        end
        @(posedge i_clk); #1; rready = 1'b1;
        first = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (arready) begin first = hs_lane0.size(); break; end
        end
        chk("full_reaccept_after", 256'(first), 256'd2);
        @(posedge i_clk); #1; arvalid = 1'b0;
        wait_idle(200);
        chk("full_beats", 256'(hs_id.size()), 256'd12);
        for (int i = 0; i < 12 && i < hs_id.size(); i++) chk("full_order", hs_id[i], 7'(i / 2 + 1));

        // WRAP
        clear_log();
        @(posedge i_clk); #1;
        send_ar(7'h21, 32'h1030, 8'd3, 3'd4, 2'd2, e0);
        wait_idle(50);
        exp_l0 = '{32'h1030, 32'h1000, 32'h1010, 32'h1020};
        chk("wrap_beats", 256'(hs_lane0.size()), 256'd4);
        for (int i = 0; i < 4 && i < hs_lane0.size(); i++) chk("wrap_lane0", hs_lane0[i], exp_l0[i]);

        // Error bursts followed by a good INCR beat
        clear_log();
        @(posedge i_clk); #1;
        send_ar(7'h33, 32'h1000, 8'd1, 3'd0, 2'd3, e0);
        send_ar(7'h34, 32'h2004, 8'd0, 3'd2, 2'd1, e0);
        send_ar(7'h35, 32'h0040, 8'd0, 3'd6, 2'd1, e0);
        wait_idle(80);
        chk("err_beats", 256'(hs_lane0.size()), 256'd4);
        if (hs_lane0.size() == 4) begin
            chk("err_resp0", hs_resp[0], 2'd2);
            chk("err_resp1", hs_resp[1], 2'd2);
            chk("err_data0", hs_lane0[0], 32'd0);
            chk("err_last0", hs_last[0], 1'b0);
            chk("err_last1", hs_last[1], 1'b1);
            chk("ok_resp", hs_resp[2], 2'd0);
            chk("ok_lane0", hs_lane0[2], 32'h2004);
            chk("ok_lane7", hs_lane7[2], 32'h2020);
            chk("size_err_resp", hs_resp[3], 2'd2);
        end

        // Reset while beat 2 of an 8-beat burst is presented, with a second command queued
        clear_log();
        @(posedge i_clk); #1;
        send_ar(7'h41, 32'h3000, 8'd7, 3'd5, 2'd1, e0);
        send_ar(7'h42, 32'h5000, 8'd1, 3'd5, 2'd1, e0);
        for (int i = 0; i < 30; i++) begin
            if (hs_lane0.size() >= 1) break;
            tick();
        end
        chk("mid_rst_pre_beats", 256'(hs_lane0.size()), 256'd1);
        @(posedge i_clk); #1; i_reset = 1'b1; rready = 1'b0;
        @(posedge i_clk); #1; i_reset = 1'b0;
        tick();
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_arready", arready, 1'b1);
        rready = 1'b1;
        repeat (8) tick();
        chk("mid_rst_no_beats", 256'(hs_lane0.size()), 256'd1);
        @(posedge i_clk); #1;
        send_ar(7'h43, 32'h4000, 8'd1, 3'd5, 2'd1, e0);
        wait_idle(50);
        chk("post_rst_beats", 256'(hs_lane0.size()), 256'd3);
        if (hs_lane0.size() == 3) begin
            chk("post_rst_lane0a", hs_lane0[1], 32'h4000);
            chk("post_rst_lane0b", hs_lane0[2], 32'h4020);
            chk("post_rst_rid", hs_id[2], 7'h43);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
